wavetable_voice_scheduler: RTL and testbench
============================================

# wavetable_voice_scheduler

Time-multiplexes a single instrument wavetable lookup (front/back phase tables with one-cycle registered read) across `VOICES` oscillator voices. On each audio sample tick it snapshots every voice's phase and oscillator state and issues them to the shared lookup one voice per cycle. It captures each returned sample into a per-voice register and accumulates a mix of all active voices. It sits between the oscillator bank and the mixer/output stage in the synthesis pipeline.

## Interface
- `VOICES`, 8, number of voices sharing the lookup (2..16)
- `PHASE_WIDTH`, `CONFIG::LONG_PERCENT_WIDTH`, lookup address width
- `AUDIO_WIDTH`, `CONFIG::AUDIO_BIT_WIDTH`, sample width; samples are two's complement
- `MIX_WIDTH`, `AUDIO_WIDTH+$clog2(VOICES)`, mix accumulator width
- `clock`  in  1  single clock; all logic is `posedge clock`
- `reset`  in  1  synchronous, active-high
- `sample_tick`  in  1  single-cycle strobe that starts a sweep
- `voice_active`  in  VOICES  per-voice enable
- `voice_state`  in  VOICES×`OSCILLATOR::oscillator_state_t`  per-voice FRONT/BACK selector
- `voice_phase`  in  VOICES×PHASE_WIDTH  per-voice phase, packed with voice 0 in the LSBs
- `lut_phase`  out  PHASE_WIDTH  address to the shared lookup
- `lut_state`  out  `oscillator_state_t`  table select to the shared lookup; must be aligned with the returned data
- `lut_sample`  in  AUDIO_WIDTH  lookup output, valid one cycle after `lut_phase`
- `voice_sample`  out  VOICES×AUDIO_WIDTH  last captured sample per voice
- `mix`  out  MIX_WIDTH  signed sum of active voice samples from the last completed sweep
- `mix_valid`  out  1  one-cycle pulse when `mix` updates
- `busy`  out  1  high from the cycle after an accepted tick through the `mix_valid` cycle
- `overrun`  out  1  sticky; set when `sample_tick` arrives while `busy`
- `overrun_clear`  in  1  clears `overrun`

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE + `sample_tick`:
  - Snapshot `voice_active`, `voice_state` and `voice_phase` into internal registers.
  - Clear the accumulator and go to ISSUE.
  - Later input changes do not affect the sweep in progress.
- ISSUE:
  - Each cycle, drive `lut_phase` with the snapshot phase of the current voice index.
  - Advance the index in ascending order.
  - After the last scheduled voice, go to DRAIN.
- Table select alignment:
  - `lut_state` is the snapshot state of the voice issued on the previous cycle, delayed one cycle so it aligns with the registered table data.
  - When no return is pending, `lut_state` holds FRONT and `lut_phase` holds 0.
- Capture:
  - On the cycle after voice i is issued, `lut_sample` is written to `voice_sample[i]`.
  - If the voice is active, `lut_sample` is also sign-extended to MIX_WIDTH and added to the accumulator.
  - Inactive voices write 0 to `voice_sample[i]` and add nothing.
- DRAIN: captures the last return, then goes to DONE.
- DONE:
  - `mix` <= accumulator and `mix_valid` = 1.
  - Return to IDLE.
- Sum width: MIX_WIDTH guarantees no overflow. The bench must confirm no wrap at full-scale inputs.
- `sample_tick` while not IDLE:
  - The tick is ignored; the sweep continues unchanged.
  - `overrun` is set.
  - If `overrun_clear` and a new overrun occur in the same cycle, set wins.
- A tick in the DONE cycle counts as overrun. A tick in the first IDLE cycle after DONE is accepted.

## Timing
- Reset values:
  - FSM = IDLE.
  - `lut_phase` = 0, `lut_state` = FRONT.
  - `voice_sample` all 0, `mix` = 0.
  - `mix_valid`, `busy` and `overrun` = 0.
- Reset asserted mid-sweep aborts the sweep immediately. No `mix_valid` is produced, and all registers take their reset values on the next edge.
- Tick accepted at cycle 0, with S scheduled voices:
  - Issues occur in cycles 1..S.
  - Captures occur in cycles 2..S+1.
  - `mix_valid` is asserted in cycle S+2.
  - `busy` is high in cycles 1..S+2.
- Maximum sustainable tick rate: one tick per S+3 cycles.
- S = 0 (possible only with skipping): go directly to DONE. `mix_valid` in cycle 1 with `mix` = 0.

## Configuration
- `WAVETABLE_SCHEDULER_SKIP_IDLE_EN`
- Defined:
  - Only voices active in the snapshot are scheduled, so S = popcount(active).
  - `voice_sample` of skipped voices is written 0 in the DONE cycle.
- Undefined:
  - All VOICES voices are always issued (S = VOICES), giving fixed latency.
  - Inactive voices still occupy a slot and are captured as 0.

## Test plan
- Reset, then VOICES=8, all active, phases 0..7, a table returning phase×3: one tick -> `lut_phase` 0..7 in cycles 1..8, `voice_sample[i]` = 3i, `mix` = 84 with `mix_valid` in cycle 10.
- Alternating FRONT/BACK states with distinct table contents -> each `lut_state` lags its phase by exactly one cycle and each capture selects the correct table.
- Active mask 8'b1000_0001 -> with macro: issues in cycles 1..2 and `mix_valid` in cycle 4. Without macro: `mix_valid` in cycle 10 and inactive `voice_sample` = 0 in both builds.
- All samples = most-negative value, all active -> `mix` = 8×(−2^(AUDIO_WIDTH−1)) with no wrap.
- Tick in cycle 5 of a sweep -> sweep and `mix` unaffected, `overrun` = 1. `overrun_clear` together with another overrun -> `overrun` stays 1; `overrun_clear` alone -> 0.
- Reset pulse in cycle 4 of a sweep -> no `mix_valid`, all outputs 0, and the next tick runs a full clean sweep.

Source files
------------

// File: rtl/wavetable_voice_scheduler.sv
// wavetable_voice_scheduler
// Shares one wavetable lookup among VOICES oscillator voices. Each sample tick
// snapshots the voice bank and issues one voice per cycle to the lookup. It
// captures the registered returns per voice and sums the active voices into a mix.
// Optional feature macro: WAVETABLE_SCHEDULER_SKIP_IDLE_EN. When it is defined,
// only voices that are active in the snapshot are issued.
module wavetable_voice_scheduler #(
  parameter int VOICES      = 8,
  parameter int PHASE_WIDTH = 16,
  parameter int AUDIO_WIDTH = 16,
  parameter int MIX_WIDTH   = AUDIO_WIDTH + $clog2(VOICES)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            sample_tick,
  input  logic [VOICES-1:0]               voice_active,
  input  logic [VOICES-1:0]               voice_state,
  input  logic [VOICES*PHASE_WIDTH-1:0]   voice_phase,
  output logic [PHASE_WIDTH-1:0]          lut_phase,
  output logic                            lut_state,
  input  logic signed [AUDIO_WIDTH-1:0]   lut_sample,
  output logic [VOICES*AUDIO_WIDTH-1:0]   voice_sample,
  output logic signed [MIX_WIDTH-1:0]     mix,
  output logic                            mix_valid,
  output logic                            busy,
  output logic                            overrun,
  input  logic                            overrun_clear
);

  localparam int   IW    = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic FRONT = 1'b0;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [VOICES-1:0]               act_q, st_q;
  logic [VOICES*PHASE_WIDTH-1:0]   ph_q;
  logic [IW-1:0]                   idx_q, idx_d;
  logic                            pend_q;
  logic [IW-1:0]                   pend_idx_q;
  logic                            lut_state_q;
  logic signed [MIX_WIDTH-1:0]     acc_q, acc_d, mix_q;
  logic [VOICES*AUDIO_WIDTH-1:0]   vs_q;
  logic                            overrun_q;
  logic                            issue;
  logic [IW:0]                     first_v, next_v;

  function automatic logic signed [MIX_WIDTH-1:0] sext(input logic signed [AUDIO_WIDTH-1:0] s);
    return {{(MIX_WIDTH-AUDIO_WIDTH){s[AUDIO_WIDTH-1]}}, s};
  endfunction

`ifdef WAVETABLE_SCHEDULER_SKIP_IDLE_EN
  // Returns {found, index} of the lowest set bit of mask at or above 'from'.
  function automatic logic [IW:0] next_active(input logic [VOICES-1:0] mask, input int from);
    logic [IW:0] r;
    r = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (v >= from && mask[v]) r = {1'b1, IW'(v)};
    end
    return r;
  endfunction
`endif

  // Next-state logic: sweep sequencing, issue index and accumulator update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    issue   = 1'b0;
`ifdef WAVETABLE_SCHEDULER_SKIP_IDLE_EN
    first_v = next_active(voice_active, 0);
    next_v  = next_active(act_q, int'(idx_q) + 1);
`else
    first_v = {1'b1, IW'(0)};
    next_v  = (idx_q == IW'(VOICES - 1)) ? '0 : {1'b1, IW'(idx_q + IW'(1))};
`endif
    if (pend_q && act_q[pend_idx_q]) acc_d = acc_q + sext(lut_sample);
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          acc_d = '0;
          if (first_v[IW]) begin
            state_d = ISSUE;
            idx_d   = first_v[IW-1:0];
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (next_v[IW]) idx_d = next_v[IW-1:0];
        else            state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registers: snapshot, return alignment, per-voice capture, mix and overrun flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      act_q       <= '0;
      st_q        <= '0;
      ph_q        <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      lut_state_q <= FRONT;
      acc_q       <= '0;
      mix_q       <= '0;
      vs_q        <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      if (state_q == IDLE && sample_tick) begin
        act_q <= voice_active;
        st_q  <= voice_state;
        ph_q  <= voice_phase;
      end
      // p0 -> p1: issue slot becomes a pending return one cycle later
      pend_q      <= issue;
      pend_idx_q  <= idx_q;
      lut_state_q <= issue ? st_q[idx_q] : FRONT;
      // p1: registered table data is valid, capture it
      if (pend_q)
        vs_q[pend_idx_q*AUDIO_WIDTH +: AUDIO_WIDTH] <= act_q[pend_idx_q] ? lut_sample : '0;
      if (state_d == DONE) mix_q <= acc_d;
`ifdef WAVETABLE_SCHEDULER_SKIP_IDLE_EN
      if (state_q == DONE) begin
        for (int v = 0; v < VOICES; v++) begin
          if (!act_q[v]) vs_q[v*AUDIO_WIDTH +: AUDIO_WIDTH] <= '0;
        end
      end
`endif
      if (sample_tick && state_q != IDLE) overrun_q <= 1'b1;
      else if (overrun_clear)             overrun_q <= 1'b0;
    end
  end

  assign lut_phase    = issue ? ph_q[idx_q*PHASE_WIDTH +: PHASE_WIDTH] : '0;
  assign lut_state    = lut_state_q;
  assign voice_sample = vs_q;
  assign mix          = mix_q;
  assign mix_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// Bench for wavetable_voice_scheduler. It uses a behavioural sweep model: the
// schedule list, table contents and the expected mix are derived directly from
// the snapshot. It covers both builds of WAVETABLE_SCHEDULER_SKIP_IDLE_EN.
module tb_wavetable_voice_scheduler;
  localparam int V  = 8;
  localparam int PW = 16;
  localparam int AW = 16;
  localparam int MW = AW + $clog2(V);
  localparam int NC = V + 4;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  sample_tick = 1'b0;
  logic                  overrun_clear = 1'b0;
  logic [V-1:0]          voice_active = '0;
  logic [V-1:0]          voice_state = '0;
  logic [V*PW-1:0]       voice_phase = '0;
  logic [PW-1:0]         lut_phase;
  logic                  lut_state;
  logic signed [AW-1:0]  lut_sample;
  logic [V*AW-1:0]       voice_sample;
  logic signed [MW-1:0]  mix;
  logic                  mix_valid, busy, overrun;

  int total = 0;
  int bad = 0;
  int tbl_mode = 0;

  wavetable_voice_scheduler #(
    .VOICES(V), .PHASE_WIDTH(PW), .AUDIO_WIDTH(AW), .MIX_WIDTH(MW)
  ) dut (
    .clock(clock), .reset(reset), .sample_tick(sample_tick),
    .voice_active(voice_active), .voice_state(voice_state), .voice_phase(voice_phase),
    .lut_phase(lut_phase), .lut_state(lut_state), .lut_sample(lut_sample),
    .voice_sample(voice_sample), .mix(mix), .mix_valid(mix_valid), .busy(busy),
    .overrun(overrun), .overrun_clear(overrun_clear)
  );

  always #5 clock = ~clock;

  // Front/back table contents; modes 1/2 force full-scale negative/positive
  function automatic logic signed [AW-1:0] tbl(input logic sel, input logic [PW-1:0] p);
    if (tbl_mode == 1) return {1'b1, {(AW-1){1'b0}}};
    if (tbl_mode == 2) return {1'b0, {(AW-1){1'b1}}};
    if (sel) return AW'(int'(p) * 7 + 1000);
    return AW'(int'(p) * 3);
  endfunction

  // Shared lookup: both tables read with a one-cycle register, selected after it
  logic signed [AW-1:0] f_q, b_q;
  always @(posedge clock) begin
    f_q <= tbl(1'b0, lut_phase);
    b_q <= tbl(1'b1, lut_phase);
  end
  assign lut_sample = lut_state ? b_q : f_q;

  // Expected per-cycle behaviour of one sweep (cycle 1 = first cycle after tick edge)
  int e_ph [0:NC];
  int e_st [0:NC];
  int e_mv [0:NC];
  int e_busy [0:NC];
  int e_vs [V];
  int e_mix;

  task automatic model_sweep(input logic [V-1:0] act, input logic [V-1:0] st,
                             input logic [V*PW-1:0] ph);
    int sched[$];
    int s, done;
    sched = {};
    for (int i = 0; i < V; i++) begin
`ifdef WAVETABLE_SCHEDULER_SKIP_IDLE_EN
      if (act[i]) sched.push_back(i);
`else
      sched.push_back(i);
`endif
    end
    s = sched.size();
    done = (s == 0) ? 1 : s + 2;
    for (int c = 0; c <= NC; c++) begin
      e_ph[c] = 0;
      e_st[c] = 0;
      if (c >= 1 && c <= s) e_ph[c] = int'(ph[sched[c-1]*PW +: PW]);
      if (c >= 2 && c <= s + 1) e_st[c] = int'(st[sched[c-2]]);
      e_mv[c]   = (c == done) ? 1 : 0;
      e_busy[c] = (c >= 1 && c <= done) ? 1 : 0;
    end
    e_mix = 0;
    for (int i = 0; i < V; i++) begin
      e_vs[i] = act[i] ? int'(tbl(st[i], ph[i*PW +: PW])) : 0;
      e_mix += e_vs[i];
    end
  endtask

  // Observed trace of one sweep
  int t_ph [0:NC];
  int t_st [0:NC];
  int t_mv [0:NC];
  int t_busy [0:NC];
  int t_ovr [0:NC];
  int t_vs [V];
  int t_mix, t_mix_end;
  logic [V-1:0]    scr_act, scr_st;
  logic [V*PW-1:0] scr_ph;

  // Starts a sweep, scrambles live inputs afterwards, optionally ticks/resets at given cycles
  task automatic run_sweep(input logic [V-1:0] act, input logic [V-1:0] st,
                           input logic [V*PW-1:0] ph, input int tick_at, input int rst_at);
    voice_active = act;
    voice_state  = st;
    voice_phase  = ph;
    sample_tick  = 1'b1;
    t_mix = 32'h7fff_ffff;
    for (int c = 1; c <= NC; c++) begin
      @(posedge clock); #1;
      sample_tick = 1'b0;
      reset = 1'b0;
      if (c == 1) begin
        voice_active = V'($urandom) | V'(1);
        voice_state  = V'($urandom);
        for (int w = 0; w < V; w++) voice_phase[w*PW +: PW] = PW'($urandom);
        scr_act = voice_active;
        scr_st  = voice_state;
        scr_ph  = voice_phase;
      end
      t_ph[c]   = int'(lut_phase);
      t_st[c]   = int'(lut_state);
      t_mv[c]   = int'(mix_valid);
      t_busy[c] = int'(busy);
      t_ovr[c]  = int'(overrun);
      if (mix_valid) t_mix = int'(mix);
      if (c == tick_at) sample_tick = 1'b1;
      if (c == rst_at) reset = 1'b1;
    end
    for (int i = 0; i < V; i++) t_vs[i] = int'($signed(voice_sample[i*AW +: AW]));
    t_mix_end = int'(mix);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sample_tick = 1'b1;
    voice_active = '1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (lut_phase !== '0) begin bad++; $display("FAIL rst_lut_phase got=%0d exp=0", lut_phase); end
    total++; if (lut_state !== 1'b0) begin bad++; $display("FAIL rst_lut_state got=%0d exp=0", lut_state); end
    total++; if (voice_sample !== '0) begin bad++; $display("FAIL rst_voice_sample got=%h exp=0", voice_sample); end
    total++; if (mix !== '0) begin bad++; $display("FAIL rst_mix got=%0d exp=0", mix); end
    total++; if ({mix_valid, busy, overrun} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {mix_valid, busy, overrun}); end
    reset = 1'b0;
    sample_tick = 1'b0;
    @(posedge clock); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_tick_ignored busy got=%0d exp=0", busy); end
  endtask

  task automatic test_sweep_patterns();
    logic [V-1:0] act, st;
    logic [V*PW-1:0] ph;
    for (int k = 0; k < 12; k++) begin
      tbl_mode = 0;
      act = '1;
      st = '0;
      for (int i = 0; i < V; i++) ph[i*PW +: PW] = PW'($urandom);
      case (k)
        0: for (int i = 0; i < V; i++) ph[i*PW +: PW] = PW'(i);
        1: st = {(V/2){2'b10}};
        2: begin act = '0; act[0] = 1'b1; act[V-1] = 1'b1; st = V'($urandom); end
        3: act = '0;
        4: tbl_mode = 1;
        5: tbl_mode = 2;
        6: begin tbl_mode = 1; st = V'($urandom); end
        default: begin act = V'($urandom); st = V'($urandom); end
      endcase
      model_sweep(act, st, ph);
      run_sweep(act, st, ph, 0, 0);
      for (int c = 1; c <= NC; c++) begin
        total++; if (t_ph[c] !== e_ph[c]) begin bad++; $display("FAIL pat%0d lut_phase cyc%0d got=%0d exp=%0d", k, c, t_ph[c], e_ph[c]); end
        total++; if (t_st[c] !== e_st[c]) begin bad++; $display("FAIL pat%0d lut_state cyc%0d got=%0d exp=%0d", k, c, t_st[c], e_st[c]); end
        total++; if (t_mv[c] !== e_mv[c]) begin bad++; $display("FAIL pat%0d mix_valid cyc%0d got=%0d exp=%0d", k, c, t_mv[c], e_mv[c]); end
        total++; if (t_busy[c] !== e_busy[c]) begin bad++; $display("FAIL pat%0d busy cyc%0d got=%0d exp=%0d", k, c, t_busy[c], e_busy[c]); end
      end
      total++; if (t_mix !== e_mix) begin bad++; $display("FAIL pat%0d mix got=%0d exp=%0d", k, t_mix, e_mix); end
      for (int i = 0; i < V; i++) begin
        total++; if (t_vs[i] !== e_vs[i]) begin bad++; $display("FAIL pat%0d voice_sample[%0d] got=%0d exp=%0d", k, i, t_vs[i], e_vs[i]); end
      end
    end
    tbl_mode = 0;
  endtask

  task automatic test_overrun();
    logic [V-1:0] st;
    logic [V*PW-1:0] ph;
    st = V'($urandom);
    for (int i = 0; i < V; i++) ph[i*PW +: PW] = PW'($urandom);
    model_sweep('1, st, ph);
    run_sweep('1, st, ph, 5, 0);
    for (int c = 1; c <= NC; c++) begin
      total++; if (t_ph[c] !== e_ph[c]) begin bad++; $display("FAIL ovr lut_phase cyc%0d got=%0d exp=%0d", c, t_ph[c], e_ph[c]); end
      total++; if (t_mv[c] !== e_mv[c]) begin bad++; $display("FAIL ovr mix_valid cyc%0d got=%0d exp=%0d", c, t_mv[c], e_mv[c]); end
    end
    total++; if (t_mix !== e_mix) begin bad++; $display("FAIL ovr mix got=%0d exp=%0d", t_mix, e_mix); end
    total++; if (t_ovr[5] !== 0) begin bad++; $display("FAIL ovr_before got=%0d exp=0", t_ovr[5]); end
    total++; if (t_ovr[6] !== 1) begin bad++; $display("FAIL ovr_set got=%0d exp=1", t_ovr[6]); end
    total++; if (t_ovr[NC] !== 1) begin bad++; $display("FAIL ovr_sticky got=%0d exp=1", t_ovr[NC]); end
    // clear coinciding with a fresh overrun: set must win
    voice_active = '1;
    sample_tick = 1'b1;
    @(posedge clock); #1;
    sample_tick = 1'b0;
    @(posedge clock); #1;
    sample_tick = 1'b1;
    overrun_clear = 1'b1;
    @(posedge clock); #1;
    sample_tick = 1'b0;
    overrun_clear = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%0d exp=1", overrun); end
    repeat (NC) @(posedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_idle busy got=%0d exp=0", busy); end
    overrun_clear = 1'b1;
    @(posedge clock); #1;
    overrun_clear = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%0d exp=0", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [V-1:0] st;
    logic [V*PW-1:0] ph;
    int seen, mix2;
    st = V'($urandom);
    for (int i = 0; i < V; i++) ph[i*PW +: PW] = PW'($urandom);
    // tick in the DONE cycle (cycle V+2) is an overrun and starts nothing
    model_sweep('1, st, ph);
    run_sweep('1, st, ph, V + 2, 0);
    total++; if (t_mv[V+2] !== 1) begin bad++; $display("FAIL b2b_done_mv got=%0d exp=1", t_mv[V+2]); end
    total++; if (t_ovr[V+3] !== 1) begin bad++; $display("FAIL b2b_done_tick_ovr got=%0d exp=1", t_ovr[V+3]); end
    total++; if (t_busy[V+3] !== 0 || t_busy[V+4] !== 0) begin bad++; $display("FAIL b2b_done_tick_busy got=%0d%0d exp=00", t_busy[V+3], t_busy[V+4]); end
    overrun_clear = 1'b1;
    @(posedge clock); #1;
    overrun_clear = 1'b0;
    // tick in the first IDLE cycle after DONE is accepted
    model_sweep('1, st, ph);
    run_sweep('1, st, ph, V + 3, 0);
    total++; if (t_mix !== e_mix) begin bad++; $display("FAIL b2b_first_mix got=%0d exp=%0d", t_mix, e_mix); end
    total++; if (t_ovr[V+4] !== 0) begin bad++; $display("FAIL b2b_idle_tick_ovr got=%0d exp=0", t_ovr[V+4]); end
    total++; if (t_busy[V+4] !== 1) begin bad++; $display("FAIL b2b_idle_tick_busy got=%0d exp=1", t_busy[V+4]); end
    model_sweep(scr_act, scr_st, scr_ph);
    total++; if (t_ph[V+4] !== e_ph[1]) begin bad++; $display("FAIL b2b_second_phase got=%0d exp=%0d", t_ph[V+4], e_ph[1]); end
    seen = 0;
    mix2 = 0;
    for (int c = 0; c < NC; c++) begin
      @(posedge clock); #1;
      if (mix_valid) begin seen++; mix2 = int'(mix); end
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL b2b_second_mv_count got=%0d exp=1", seen); end
    total++; if (mix2 !== e_mix) begin bad++; $display("FAIL b2b_second_mix got=%0d exp=%0d", mix2, e_mix); end
  endtask

  task automatic test_reset_mid();
    logic [V-1:0] st;
    logic [V*PW-1:0] ph;
    int mvs;
    st = V'($urandom);
    for (int i = 0; i < V; i++) ph[i*PW +: PW] = PW'(($urandom % 1000) + 1);
    run_sweep('1, st, ph, 2, 4);
    mvs = 0;
    for (int c = 1; c <= NC; c++) mvs += t_mv[c];
    total++; if (t_busy[4] !== 1) begin bad++; $display("FAIL rmid_busy_before got=%0d exp=1", t_busy[4]); end
    total++; if (t_ovr[3] !== 1) begin bad++; $display("FAIL rmid_ovr_before got=%0d exp=1", t_ovr[3]); end
    total++; if (mvs !== 0) begin bad++; $display("FAIL rmid_no_mix_valid got=%0d exp=0", mvs); end
    total++; if (t_busy[5] !== 0 || t_ph[5] !== 0 || t_st[5] !== 0 || t_ovr[5] !== 0) begin
      bad++; $display("FAIL rmid_outputs got=busy%0d ph%0d st%0d ovr%0d exp=0", t_busy[5], t_ph[5], t_st[5], t_ovr[5]);
    end
    total++; if (t_mix_end !== 0) begin bad++; $display("FAIL rmid_mix got=%0d exp=0", t_mix_end); end
    for (int i = 0; i < V; i++) begin
      total++; if (t_vs[i] !== 0) begin bad++; $display("FAIL rmid_voice_sample[%0d] got=%0d exp=0", i, t_vs[i]); end
    end
    model_sweep('1, st, ph);
    run_sweep('1, st, ph, 0, 0);
    for (int c = 1; c <= NC; c++) begin
      total++; if (t_mv[c] !== e_mv[c]) begin bad++; $display("FAIL rmid_clean mix_valid cyc%0d got=%0d exp=%0d", c, t_mv[c], e_mv[c]); end
    end
    total++; if (t_mix !== e_mix) begin bad++; $display("FAIL rmid_clean_mix got=%0d exp=%0d", t_mix, e_mix); end
    for (int i = 0; i < V; i++) begin
      total++; if (t_vs[i] !== e_vs[i]) begin bad++; $display("FAIL rmid_clean_vs[%0d] got=%0d exp=%0d", i, t_vs[i], e_vs[i]); end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sweep_patterns();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
